// File: rtl/pb_fb_router_pipe_pkg.sv
// Shared definitions for the frontend M-Bus pipelined router.
// Provides bus widths (overridable through NCPU_AW / NCPU_DW), the default
// decode-error data word and a ceiling-log2 helper for pointer sizing.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

`ifndef NCPU_DW
`define NCPU_DW 32
`endif

package pb_fb_router_pipe_pkg;

  localparam int unsigned AW = `NCPU_AW;
  localparam int unsigned DW = `NCPU_DW;

  localparam int unsigned MW = DW / 8;

  localparam logic [31:0] PB_FB_ROUTE_ERR_DATA = 32'hDEAD_BEEF;

  // Ceiling log2, used for FIFO pointer widths
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_fb_router_pipe_fifo.sv
// pb_fb_route_fifo: generic synchronous FIFO with a combinational head.
// Ports: clk, rst (async active-high), push/din, pop, head, full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pb_fb_route_fifo
  import pb_fb_router_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[PW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage and pointers; reset clears every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pb_fb_router_pipe.sv
// pb_fb_router_pipe: routes one frontend M-Bus to NBUS slave buses with up to
// DEPTH outstanding commands; responses return in issue order. Unmapped
// commands (fb_bus_sel == 0) complete with ERR_DATA and fb_mbus_err set.
// Ports: clk, rst (async active-high); fb_mbus_* frontend command/response;
// fb_bus_* per-slave command/response (addr, din, we_msk broadcast).
// Optional macro PB_FB_ROUTER_PIPE_PERF_EN adds perf_stall_cnt[31:0], a
// saturating count of cycles with a command offered but not accepted.
module pb_fb_router_pipe
  import pb_fb_router_pipe_pkg::*;
#(
  parameter int unsigned   NBUS     = 4,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [DW-1:0] ERR_DATA = DW'(PB_FB_ROUTE_ERR_DATA)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fb_mbus_valid,
  input  logic               fb_mbus_ready,
  output logic [DW-1:0]      fb_mbus_dout,
  output logic               fb_mbus_err,
  input  logic [DW-1:0]      fb_mbus_din,
  input  logic               fb_mbus_cmd_valid,
  output logic               fb_mbus_cmd_ready,
  input  logic [AW-1:0]      fb_mbus_cmd_addr,
  input  logic [MW-1:0]      fb_mbus_cmd_we_msk,
  input  logic [NBUS-1:0]    fb_bus_sel,
  input  logic [NBUS-1:0]    fb_bus_valid,
  output logic [NBUS-1:0]    fb_bus_ready,
  input  logic [NBUS*DW-1:0] fb_bus_dout,
  output logic [NBUS*DW-1:0] fb_bus_din,
  input  logic [NBUS-1:0]    fb_bus_cmd_ready,
  output logic [NBUS-1:0]    fb_bus_cmd_valid,
  output logic [NBUS*AW-1:0] fb_bus_cmd_addr,
  output logic [NBUS*MW-1:0] fb_bus_cmd_we_msk
`ifdef PB_FB_ROUTER_PIPE_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic            full;
  logic            empty;
  logic [NBUS:0]   head;
  logic            head_err;
  logic [NBUS-1:0] head_id;
  logic            unmapped;
  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [DW-1:0]   sel_dout;

  // Route FIFO entry: {decode error, one-hot bus id}
  pb_fb_route_fifo #(
    .WIDTH (NBUS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({unmapped, fb_bus_sel}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_err = head[NBUS];
  assign head_id  = head[NBUS-1:0];
  assign unmapped = ~|fb_bus_sel;

  // Command path; rst gating keeps handshakes low while reset is held
  assign fb_bus_cmd_valid  = {NBUS{fb_mbus_cmd_valid & ~full & ~rst}} & fb_bus_sel;
  assign fb_mbus_cmd_ready = ~rst & ~full & (unmapped | (|(fb_bus_sel & fb_bus_cmd_ready)));
  assign push              = fb_mbus_cmd_valid & fb_mbus_cmd_ready;

  assign fb_bus_din        = {NBUS{fb_mbus_din}};
  assign fb_bus_cmd_addr   = {NBUS{fb_mbus_cmd_addr}};
  assign fb_bus_cmd_we_msk = {NBUS{fb_mbus_cmd_we_msk}};

  // Select the head bus's response
  always_comb begin
    sel_valid = |(head_id & fb_bus_valid);
    sel_dout  = '0;
    for (int j = 0; j < int'(NBUS); j++) begin
      if (head_id[j]) sel_dout = fb_bus_dout[j*DW +: DW];
    end
  end

  // Response path; only the head bus is ever given ready
  assign fb_mbus_valid = ~empty & (head_err | sel_valid);
  assign fb_mbus_dout  = head_err ? ERR_DATA : sel_dout;
  assign fb_mbus_err   = ~empty & head_err;
  assign fb_bus_ready  = {NBUS{fb_mbus_ready & ~empty & ~head_err}} & head_id;
  assign pop           = fb_mbus_valid & fb_mbus_ready;

`ifdef PB_FB_ROUTER_PIPE_PERF_EN
  // Saturating count of stalled command cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (fb_mbus_cmd_valid && !fb_mbus_cmd_ready && !(&perf_stall_cnt)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A multi-hot select has no defined routing
  always @(posedge clk) begin
    if (!rst && fb_mbus_cmd_valid && !$onehot0(fb_bus_sel))
      $fatal(1, "pb_fb_router_pipe: more than one fb_bus_sel bit set");
  end
`endif

endmodule

// File: tb/tb_pb_fb_router_pipe.sv
// Directed bench for pb_fb_router_pipe (NBUS=4, DEPTH=4, 32-bit buses).
module tb_pb_fb_router_pipe;

  logic         clk;
  logic         rst;
  logic         mbus_valid;
  logic         mbus_ready;
  logic [31:0]  mbus_dout;
  logic         mbus_err;
  logic [31:0]  mbus_din;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_addr;
  logic [3:0]   cmd_we_msk;
  logic [3:0]   bus_sel;
  logic [3:0]   bus_valid;
  logic [3:0]   bus_ready;
  logic [127:0] bus_dout;
  logic [127:0] bus_din;
  logic [3:0]   bus_cmd_ready;
  logic [3:0]   bus_cmd_valid;
  logic [127:0] bus_cmd_addr;
  logic [15:0]  bus_cmd_we_msk;
`ifdef PB_FB_ROUTER_PIPE_PERF_EN
  logic [31:0]  perf_stall_cnt;
`endif

  int total;
  int bad;

  pb_fb_router_pipe #(
    .NBUS  (4),
    .DEPTH (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fb_mbus_valid      (mbus_valid),
    .fb_mbus_ready      (mbus_ready),
    .fb_mbus_dout       (mbus_dout),
    .fb_mbus_err        (mbus_err),
    .fb_mbus_din        (mbus_din),
    .fb_mbus_cmd_valid  (cmd_valid),
    .fb_mbus_cmd_ready  (cmd_ready),
    .fb_mbus_cmd_addr   (cmd_addr),
    .fb_mbus_cmd_we_msk (cmd_we_msk),
    .fb_bus_sel         (bus_sel),
    .fb_bus_valid       (bus_valid),
    .fb_bus_ready       (bus_ready),
    .fb_bus_dout        (bus_dout),
    .fb_bus_din         (bus_din),
    .fb_bus_cmd_ready   (bus_cmd_ready),
    .fb_bus_cmd_valid   (bus_cmd_valid),
    .fb_bus_cmd_addr    (bus_cmd_addr),
    .fb_bus_cmd_we_msk  (bus_cmd_we_msk)
`ifdef PB_FB_ROUTER_PIPE_PERF_EN
    ,
    .perf_stall_cnt     (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    mbus_ready    = 1'b0;
    mbus_din      = 32'hCAFE_0001;
    cmd_valid     = 1'b1;
    cmd_addr      = 32'h0000_1000;
    cmd_we_msk    = 4'hF;
    bus_sel       = 4'b0010;
    bus_valid     = 4'b0010;
    bus_dout      = '0;
    bus_cmd_ready = 4'b1111;

    // Reset: all handshake outputs low despite active inputs
    #2;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b0));
    chk("rst_bus_cmd_valid", 128'(bus_cmd_valid), 128'(4'b0000));
    chk("rst_mbus_valid", 128'(mbus_valid), 128'(1'b0));
    chk("rst_bus_ready", 128'(bus_ready), 128'(4'b0000));
    tick();
    rst       = 1'b0;
    bus_valid = 4'b0000;
    #1;

    // Single read to bus 1
    chk("rd1_bus_cmd_valid", 128'(bus_cmd_valid), 128'(4'b0010));
    chk("rd1_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    chk("rd1_addr_bcast", bus_cmd_addr, {4{32'h0000_1000}});
    chk("rd1_din_bcast", bus_din, {4{32'hCAFE_0001}});
    chk("rd1_msk_bcast", 128'(bus_cmd_we_msk), 128'(16'hFFFF));
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("rd1_wait_valid", 128'(mbus_valid), 128'(1'b0));
    bus_valid           = 4'b0010;
    bus_dout[32 +: 32]  = 32'h1234_5678;
    mbus_ready          = 1'b1;
    #1;
    chk("rd1_valid", 128'(mbus_valid), 128'(1'b1));
    chk("rd1_dout", 128'(mbus_dout), 128'(32'h1234_5678));
    chk("rd1_err", 128'(mbus_err), 128'(1'b0));
    chk("rd1_bus_ready", 128'(bus_ready), 128'(4'b0010));
    tick();
    chk("rd1_empty_valid", 128'(mbus_valid), 128'(1'b0));
    chk("rd1_empty_ready", 128'(bus_ready), 128'(4'b0000));

    // Bus 2 then bus 0; bus 0 answers first and must be held
    bus_valid  = 4'b0000;
    mbus_ready = 1'b0;
    cmd_valid  = 1'b1;
    bus_sel    = 4'b0100;
    tick();
    bus_sel = 4'b0001;
    tick();
    cmd_valid          = 1'b0;
    mbus_ready         = 1'b1;
    bus_valid          = 4'b0001;
    bus_dout[0 +: 32]  = 32'hAAAA_0000;
    bus_dout[64 +: 32] = 32'hBBBB_2222;
    #1;
    chk("ord_hold_valid", 128'(mbus_valid), 128'(1'b0));
    chk("ord_hold_ready", 128'(bus_ready), 128'(4'b0100));
    bus_valid = 4'b0101;
    #1;
    chk("ord_b2_valid", 128'(mbus_valid), 128'(1'b1));
    chk("ord_b2_dout", 128'(mbus_dout), 128'(32'hBBBB_2222));
    tick();
    bus_valid = 4'b0001;
    #1;
    chk("ord_b0_valid", 128'(mbus_valid), 128'(1'b1));
    chk("ord_b0_dout", 128'(mbus_dout), 128'(32'hAAAA_0000));
    chk("ord_b0_ready", 128'(bus_ready), 128'(4'b0001));
    tick();
    chk("ord_empty", 128'(mbus_valid), 128'(1'b0));

    // Fill to DEPTH with responses blocked, then free one slot
    bus_valid          = 4'b0000;
    mbus_ready         = 1'b0;
    bus_dout[96 +: 32] = 32'h3333_3333;
    bus_sel            = 4'b1000;
    cmd_valid          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("full_acc%0d", i), 128'(cmd_ready), 128'(1'b1));
      tick();
    end
    #1;
    chk("full_block_ready", 128'(cmd_ready), 128'(1'b0));
    chk("full_block_valid", 128'(bus_cmd_valid), 128'(4'b0000));
    bus_valid  = 4'b1000;
    mbus_ready = 1'b1;
    #1;
    chk("full_pop_block", 128'(cmd_ready), 128'(1'b0));
    chk("full_pop_valid", 128'(mbus_valid), 128'(1'b1));
    tick();
    mbus_ready = 1'b0;
    #1;
    chk("full_after_pop", 128'(cmd_ready), 128'(1'b1));
    tick();
    cmd_valid  = 1'b0;
    mbus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_valid%0d", i), 128'(mbus_valid), 128'(1'b1));
      chk($sformatf("drain_dout%0d", i), 128'(mbus_dout), 128'(32'h3333_3333));
      tick();
    end
    chk("drain_empty", 128'(mbus_valid), 128'(1'b0));

    // Unmapped command completes with a decode error
    bus_valid     = 4'b0000;
    mbus_ready    = 1'b0;
    bus_cmd_ready = 4'b0000;
    bus_sel       = 4'b0000;
    cmd_valid     = 1'b1;
    #1;
    chk("unm_cmd_ready", 128'(cmd_ready), 128'(1'b1));
    chk("unm_bus_cmd_valid", 128'(bus_cmd_valid), 128'(4'b0000));
    chk("unm_early_valid", 128'(mbus_valid), 128'(1'b0));
    tick();
    cmd_valid  = 1'b0;
    mbus_ready = 1'b1;
    bus_valid  = 4'b1111;
    #1;
    chk("unm_valid", 128'(mbus_valid), 128'(1'b1));
    chk("unm_dout", 128'(mbus_dout), 128'(32'hDEAD_BEEF));
    chk("unm_err", 128'(mbus_err), 128'(1'b1));
    chk("unm_bus_ready", 128'(bus_ready), 128'(4'b0000));
    tick();
    chk("unm_popped", 128'(mbus_valid), 128'(1'b0));
    chk("unm_err_clr", 128'(mbus_err), 128'(1'b0));

    // Reset with three outstanding commands
    bus_valid     = 4'b0000;
    mbus_ready    = 1'b0;
    bus_cmd_ready = 4'b1111;
    bus_sel       = 4'b0010;
    cmd_valid     = 1'b1;
    repeat (3) tick();
    bus_valid  = 4'b0010;
    mbus_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_mbus_valid", 128'(mbus_valid), 128'(1'b0));
    chk("mrst_cmd_ready", 128'(cmd_ready), 128'(1'b0));
    chk("mrst_bus_cmd_valid", 128'(bus_cmd_valid), 128'(4'b0000));
    chk("mrst_bus_ready", 128'(bus_ready), 128'(4'b0000));
    tick();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("mrst_no_stale", 128'(mbus_valid), 128'(1'b0));
    bus_valid = 4'b0000;
    bus_sel   = 4'b0100;
    cmd_valid = 1'b1;
    #1;
    chk("mrst_new_ready", 128'(cmd_ready), 128'(1'b1));
    tick();
    cmd_valid          = 1'b0;
    bus_valid          = 4'b0100;
    bus_dout[64 +: 32] = 32'h55AA_55AA;
    #1;
    chk("mrst_new_valid", 128'(mbus_valid), 128'(1'b1));
    chk("mrst_new_dout", 128'(mbus_dout), 128'(32'h55AA_55AA));
    tick();
    chk("mrst_new_empty", 128'(mbus_valid), 128'(1'b0));

`ifdef PB_FB_ROUTER_PIPE_PERF_EN
    // Seven stalled cycles against a busy slave
    bus_valid = 4'b0000;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("perf_clear", 128'(perf_stall_cnt), 128'(32'd0));
    bus_cmd_ready = 4'b0000;
    bus_sel       = 4'b0001;
    cmd_valid     = 1'b1;
    repeat (7) tick();
    cmd_valid = 1'b0;
    #1;
    chk("perf_cnt7", 128'(perf_stall_cnt), 128'(32'd7));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
